// File: rtl/halfword_fetch_queue_if.sv
// Fetch-queue bundle: downstream stall/jump, instruction-cache request/response and head half-word.
// Optional HWQ_PC_TRACK_EN adds half_pc_o, the byte address of the head half-word.
interface halfword_fetch_queue_if;
    logic        stall;
    logic        jump;
    logic [31:0] jump_target;
    logic        ic_read;
    logic [29:0] ic_addr;
    logic        ic_stall;
    logic [31:0] ic_rdata;
    logic [15:0] half_o;
    logic        half_valid_o;
`ifdef HWQ_PC_TRACK_EN
    logic [31:0] half_pc_o;

    modport master (
        input  stall, jump, jump_target, ic_stall, ic_rdata,
        output ic_read, ic_addr, half_o, half_valid_o, half_pc_o
    );
    modport slave (
        output stall, jump, jump_target, ic_stall, ic_rdata,
        input  ic_read, ic_addr, half_o, half_valid_o, half_pc_o
    );
`else
    modport master (
        input  stall, jump, jump_target, ic_stall, ic_rdata,
        output ic_read, ic_addr, half_o, half_valid_o
    );
    modport slave (
        output stall, jump, jump_target, ic_stall, ic_rdata,
        input  ic_read, ic_addr, half_o, half_valid_o
    );
`endif
endinterface

// File: rtl/halfword_fetch_queue.sv
// Prefetch queue: fetches cache words, splits them into half-words and delivers them in order.
// Define HWQ_PC_TRACK_EN to store a byte address per entry and drive half_pc_o.
module halfword_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                    clk,
    input logic                    rst_n,
    halfword_fetch_queue_if.master bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    typedef enum logic [0:0] {StRun, StRedirect} state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [29:0]     fetch_addr_q, fetch_addr_d;
    logic            skip_hi_q, skip_hi_d;
    logic [15:0]     mem_q [DEPTH];

    logic            slot_ok;
    logic            accept;
    logic            pop;
    logic            push_two;
    logic [1:0]      push_cnt;
    logic [15:0]     first_half;
    logic [AW-1:0]   wr_ptr_nxt;
    logic            unused_target_lsb;

    assign unused_target_lsb = bus.jump_target[0];

    // Free-slot test uses the pre-pop count, so a full word always fits.
    assign slot_ok    = (count_q <= CW'(DEPTH - 2));
    assign bus.ic_read = ~bus.jump & (state_q == StRun) & slot_ok;
    assign bus.ic_addr = fetch_addr_q;
    assign accept     = bus.ic_read & ~bus.ic_stall;
    assign pop        = (count_q != '0) & ~bus.stall & ~bus.jump;
    assign push_two   = accept & ~skip_hi_q;
    assign push_cnt   = accept ? (skip_hi_q ? 2'd1 : 2'd2) : 2'd0;
    assign first_half = skip_hi_q ? bus.ic_rdata[15:0] : bus.ic_rdata[31:16];
    assign wr_ptr_nxt = wr_ptr_q + AW'(1);

    assign bus.half_o       = mem_q[rd_ptr_q];
    assign bus.half_valid_o = (count_q != '0);

    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        fetch_addr_d = fetch_addr_q;
        skip_hi_d    = skip_hi_q;
        if (bus.jump) begin
            state_d      = StRedirect;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            fetch_addr_d = bus.jump_target[31:2];
            skip_hi_d    = bus.jump_target[1];
        end else begin
            state_d  = StRun;
            rd_ptr_d = rd_ptr_q + AW'(pop);
            wr_ptr_d = wr_ptr_q + AW'(push_cnt);
            count_d  = count_q + CW'(push_cnt) - CW'(pop);
            if (accept) begin
                fetch_addr_d = fetch_addr_q + 30'd1;
                skip_hi_d    = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StRun;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            fetch_addr_q <= RESET_PC[31:2];
            skip_hi_q    <= RESET_PC[1];
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            fetch_addr_q <= fetch_addr_d;
            skip_hi_q    <= skip_hi_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (accept) begin
            mem_q[wr_ptr_q] <= first_half;
            if (push_two) mem_q[wr_ptr_nxt] <= bus.ic_rdata[15:0];
        end
    end

`ifdef HWQ_PC_TRACK_EN
    logic [31:0] pc_mem_q [DEPTH];
    logic [31:0] last_pc_q;

    // Empty queue keeps presenting the address of the last head entry.
    assign bus.half_pc_o = bus.half_valid_o ? pc_mem_q[rd_ptr_q] : last_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pc_mem_q[i] <= '0;
            last_pc_q <= RESET_PC;
        end else begin
            last_pc_q <= bus.half_pc_o;
            if (accept) begin
                pc_mem_q[wr_ptr_q] <= {fetch_addr_q, skip_hi_q, 1'b0};
                if (push_two) pc_mem_q[wr_ptr_nxt] <= {fetch_addr_q, 2'b10};
            end
        end
    end
`endif

endmodule

// File: doc/halfword_fetch_queue.md
# halfword_fetch_queue

Fetch-side prefetch queue that sits directly upstream of the half-word alignment/decompression stage. It issues word reads to the instruction cache, splits each returned 32-bit word into two 16-bit half-words, and delivers them in address order, one per non-stalled cycle. It also handles redirection on jump, including jump targets on a half-word boundary.

## Interface
Parameters:
- DEPTH, 4, half-word queue entries; power of two, ≥ 4
- RESET_PC, 32'h0000_0000, fetch byte address after reset; bit 0 must be 0

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  reset; asynchronous, active-low
- stall  in  1  downstream stall; no half-word consumed this cycle
- jump  in  1  redirect request; flushes the queue
- jump_target  in  32  byte address of the redirect target; bit 0 ignored
- ic_read  out  1  cache read request
- ic_addr  out  30  word address of the request (byte address [31:2])
- ic_stall  in  1  cache busy; the request is not accepted this cycle
- ic_rdata  in  32  read data, valid in any cycle with ic_read & ~ic_stall
- half_o  out  16  head half-word, in raw cache byte order (the consumer performs the byte swap)
- half_valid_o  out  1  half_o holds a real half-word
- half_pc_o  out  32  byte address of half_o (only with HWQ_PC_TRACK_EN)

## Operation
- Queue: circular buffer of DEPTH half-words, with rd_ptr, wr_ptr and count (log2(DEPTH)+1 bits). half_o = entry[rd_ptr]. half_valid_o = (count != 0).
- Pop: taken when half_valid_o & ~stall & ~jump. Advances rd_ptr by 1, modulo DEPTH.
- Request: ic_read = ~jump & (DEPTH − count ≥ 2). ic_addr = fetch_addr register.
- Accept: a cycle with ic_read & ~ic_stall.
  - Push ic_rdata[31:16] (lower address) and then ic_rdata[15:0], unless skip_hi = 1. With skip_hi = 1, push only ic_rdata[15:0] and clear skip_hi.
  - Increment fetch_addr by 1, wrapping at 2^30.
- Simultaneous push and pop: count += pushed − popped. Free-slot check uses count before the pop, so the queue never overflows.
- Empty queue: half_valid_o = 0. half_o is don't-care and must not be relied on.
- FSM states:
  - RUN: requests issued whenever the slot check passes.
  - REDIRECT: entered for one cycle after jump. The queue is empty, ic_read = 0, and the next state is RUN.
- Jump (highest priority, even with stall = 1):
  - Any request in this cycle is dropped: ic_read = 0, no push.
  - No pop; count ← 0; rd_ptr = wr_ptr ← 0.
  - fetch_addr ← jump_target[31:2]; skip_hi ← jump_target[1]; state ← REDIRECT.
- ic_stall held: ic_read and ic_addr stay stable until accepted or until a jump.
- Reset: count = 0, pointers = 0, fetch_addr = RESET_PC[31:2], skip_hi = RESET_PC[1], state = RUN.

## Timing
- Reset values: half_valid_o = 0, half_o = 16'h0000, half_pc_o = RESET_PC.
  - Cycle after reset release: ic_read = 1, ic_addr = RESET_PC[31:2].
- Fetch latency: word accepted in cycle t → its first half-word is on half_o with half_valid_o = 1 in cycle t+1.
- Jump latency:
  - jump in cycle t → REDIRECT in t+1 (ic_read = 0).
  - First request at target in t+2 → half_valid_o at t+3 at the earliest.
- Steady state (no ic_stall): the queue sustains one half-word per cycle with no bubbles.
- Reset asserted mid-operation: all state clears immediately (asynchronously). An in-flight cache acceptance is discarded.

## Configuration
- HWQ_PC_TRACK_EN defined:
  - Adds a per-entry address store and the half_pc_o port.
  - half_pc_o = byte address of half_o; each pushed half-word carries {fetch_addr, 2'b00} or {fetch_addr, 2'b10}.
  - When empty, half_pc_o holds the last value.
- Not defined: no address storage and no half_pc_o port. Queue behaviour is otherwise identical.

## Test plan
- Reset with RESET_PC = 0, ic_rdata = 32'hAAAA_BBBB at word 0, 32'hCCCC_DDDD at word 1, no stalls → half_o sequence AAAA, BBBB, CCCC, DDDD on consecutive cycles starting one cycle after the first accept.
- stall held 6 cycles with DEPTH = 4 → count reaches 4, ic_read drops to 0, no entry overwritten. After release, the half-word order is unchanged.
- jump_target = 32'h0000_0102 while the queue is full → queue empties next cycle. ic_addr = 30'h40 two cycles after the jump. The first half_o is ic_rdata[15:0] of word 0x40 (with HWQ_PC_TRACK_EN, half_pc_o = 32'h102).
- ic_stall held 3 cycles on a request → ic_read and ic_addr stable throughout, no push. The queue drains while stall = 0, and half_valid_o falls to 0 when empty.
- jump asserted in the same cycle as an accepted request with stall = 1 → no push, no pop, and the queue flushes.
- fetch_addr = 30'h3FFF_FFFF accepted → next ic_addr = 30'h0.
- Reset asserted mid-stream → half_valid_o = 0 immediately, without waiting for a clock edge.
